led_sequencer: RTL and testbench
================================

# led_sequencer

Output stage fed by the 16-bit `out_led` word of the myrisc16 core. Detects every change of that word, buffers up to four pending values, and replays each one on the icestick's five LEDs as four timed nibbles (most-significant first) with a marker LED and an inter-word gap. This makes fast register writes from the core observable by eye, and it flags any values lost to buffer overflow.

## Interface
Parameters:
- `HOLD_LOG2`, default 22: each display phase lasts 2^HOLD_LOG2 clocks (about 0.35 s at 12 MHz). Legal range is 1..24.

Ports:
- `in_clock`  input  1  sole clock; all state is on the rising edge.
- `in_reset`  input  1  asynchronous, active-high reset.
- `in_led`  input  16  word from the core; synchronous to `in_clock`.
- `out_led`  output  5  LED drive. [3:0] carry the current nibble; [4] is the first-nibble marker (green D5).
- `out_overflow`  output  1  sticky flag: a change was dropped because the FIFO was full.
- `out_fifo_count`  output  3  pending entries, 0..4.

## Operation
- Change detect:
  - Register `last_seen` (reset 16'h0000) is compared with `in_led` every cycle.
  - On inequality, the next edge loads `last_seen <= in_led` and requests a push of `in_led`.
  - `last_seen` updates even when the push is dropped.
- FIFO:
  - 4 entries, 2-bit read and write pointers that wrap modulo 4, and a 3-bit count.
  - Push when full, with no pop on the same edge: value is dropped and `out_overflow` is set. It clears only on reset.
  - Push and pop on the same edge: both take effect and the count is unchanged. This holds when full, so no drop occurs.
  - Pop is only issued when the FIFO is non-empty, so empty-pop does not arise.
- Display FSM (2-bit phase state plus 2-bit nibble index):
  - IDLE: `out_led` = 0. If count is non-zero: pop into `shown`, set index to 3, reset the timer, go to SHOW.
  - SHOW:
    - `out_led[3:0]` = `shown[4*idx+3 : 4*idx]`; `out_led[4]` = (idx==3).
    - The timer (HOLD_LOG2 bits) increments each clock.
    - When the timer is all-ones: if idx==0, go to GAP; otherwise decrement idx. The timer wraps to 0 either way.
  - GAP: `out_led` = 0 for 2^HOLD_LOG2 clocks, then go to IDLE.
  - The fourth state encoding is unused and recovers to IDLE on the next edge.
- `out_led` is registered and is decoded from the next state and next index, so it changes on the same edge as the state.
- Reset mid-operation: all state clears at once. FIFO contents are discarded, `out_led` goes to 0, `out_overflow` goes to 0, and `last_seen` goes to 0.

## Timing
- Reset values: `out_led`=5'h00, `out_overflow`=0, `out_fifo_count`=0, state=IDLE, timer=0, `shown`=0, `last_seen`=0.
- Change-to-display latency, with the FSM idle and the FIFO empty:
  - `in_led` differs before edge E0.
  - E0: push; `out_fifo_count`=1 after E0.
  - E1: pop; nibble 3 with marker is visible after E1, and count returns to 0.
- Word period: 5·2^HOLD_LOG2 clocks (4 nibbles plus the gap), plus 1 IDLE clock before the next pop.
- A change lasting a single clock is captured, and so is a return to the previous value on the next clock. Each transition is a separate push.
- The first word after reset is pushed only if it is non-zero, because `last_seen` resets to 0.

## Test plan
All scenarios use HOLD_LOG2=2 (4-clock phases).
- Single value: after reset drive `in_led`=16'hA5C3 and hold it. Required `out_led` sequence, 4 clocks each: 5'h1A, 5'h05, 5'h0C, 5'h03, then 5'h00 for 4 clocks, then 5'h00 forever. Count reads 1 for exactly one cycle.
- Back-to-back changes: drive 16'h1111, 16'h2222, 16'h3333 on consecutive clocks. Count must reach 2 and not exceed it, since one entry is popped first. The three words display in order, separated by 4-clock gaps plus 1 IDLE clock.
- Overflow: drive 6 distinct values on consecutive clocks while the first word is displaying. The FIFO holds 4 entries, `out_overflow` rises on the dropped push and stays high, and the first 5 values display (the one already popped plus 4 queued).
- Full with simultaneous push and pop: hold count at 4, then change `in_led` on the exact IDLE-pop edge. Count stays 4, `out_overflow` stays 0, and the new value is displayed last.
- Reset mid-display: assert `in_reset` during nibble 2 of a word with 3 entries queued. All outputs go to 0 immediately (asynchronously), and after deassertion nothing displays until `in_led` differs from 0.
- Zero after reset: keep `in_led`=0, then drive 0→0x0001→0. Both changes are pushed and shown: first 5'h10, 5'h00, 5'h00, 5'h01, then 5'h10 with all nibbles 0.

Source files
------------

// File: rtl/led_sequencer.sv
// Replays every change of a 16-bit core word on five LEDs as four timed nibbles
// (MS nibble first, D5 marks the first) followed by a blank gap; up to four words queue.
module led_sequencer #(
    parameter int HOLD_LOG2 = 22
) (
    input  logic        in_clock,
    input  logic        in_reset,
    input  logic [15:0] in_led,
    output logic [4:0]  out_led,
    output logic        out_overflow,
    output logic [2:0]  out_fifo_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SHOW = 2'd1,
        ST_GAP  = 2'd2,
        ST_BAD  = 2'd3
    } state_t;

    state_t                 state_reg, state_next;
    logic [1:0]             idx_reg, idx_next;
    logic [HOLD_LOG2-1:0]   timer_reg, timer_next;
    logic [15:0]            shown_reg, shown_next;
    logic [4:0]             out_led_reg, out_led_next;

    logic [15:0]            last_seen_reg;
    logic [15:0]            fifo_mem [0:3];
    logic [1:0]             wr_ptr_reg, rd_ptr_reg;
    logic [2:0]             count_reg, count_next;
    logic                   overflow_reg, overflow_next;

    logic                   push_req, push_ok, pop, full;

    assign full     = (count_reg == 3'd4);
    assign push_req = (in_led != last_seen_reg);
    // A push into a full FIFO still succeeds when the display pops on the same edge.
    assign push_ok  = push_req && (!full || pop);

    always_comb begin
        count_next    = count_reg;
        overflow_next = overflow_reg;
        case ({push_ok, pop})
            2'b10:   count_next = count_reg + 3'd1;
            2'b01:   count_next = count_reg - 3'd1;
            default: count_next = count_reg;
        endcase
        if (push_req && !push_ok)
            overflow_next = 1'b1;
    end

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        timer_next = timer_reg;
        shown_next = shown_reg;
        pop        = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (count_reg != 3'd0) begin
                    pop        = 1'b1;
                    shown_next = fifo_mem[rd_ptr_reg];
                    idx_next   = 2'd3;
                    timer_next = '0;
                    state_next = ST_SHOW;
                end
            end
            ST_SHOW: begin
                timer_next = timer_reg + 1'b1;
                if (timer_reg == '1) begin
                    if (idx_reg == 2'd0)
                        state_next = ST_GAP;
                    else
                        idx_next = idx_reg - 1'b1;
                end
            end
            ST_GAP: begin
                timer_next = timer_reg + 1'b1;
                if (timer_reg == '1)
                    state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase

        // Decoded from next-state values so the LEDs switch on the same edge as the FSM.
        out_led_next = 5'h00;
        if (state_next == ST_SHOW)
            out_led_next = {(idx_next == 2'd3), shown_next[{idx_next, 2'b00} +: 4]};
    end

    always_ff @(posedge in_clock) begin
        if (push_ok)
            fifo_mem[wr_ptr_reg] <= in_led;
    end

    always_ff @(posedge in_clock or posedge in_reset) begin
        if (in_reset) begin
            state_reg     <= ST_IDLE;
            idx_reg       <= 2'd0;
            timer_reg     <= '0;
            shown_reg     <= 16'h0000;
            out_led_reg   <= 5'h00;
            last_seen_reg <= 16'h0000;
            wr_ptr_reg    <= 2'd0;
            rd_ptr_reg    <= 2'd0;
            count_reg     <= 3'd0;
            overflow_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            idx_reg       <= idx_next;
            timer_reg     <= timer_next;
            shown_reg     <= shown_next;
            out_led_reg   <= out_led_next;
            last_seen_reg <= in_led;
            count_reg     <= count_next;
            overflow_reg  <= overflow_next;
            if (push_ok)
                wr_ptr_reg <= wr_ptr_reg + 2'd1;
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + 2'd1;
        end
    end

    assign out_led        = out_led_reg;
    assign out_overflow   = overflow_reg;
    assign out_fifo_count = count_reg;

endmodule

// File: tb/tb_led_sequencer.sv
// Directed bench: stimulus queues expected words, a monitor checks every displayed word cycle by cycle.
module tb_led_sequencer;

    logic        in_clock;
    logic        in_reset;
    logic [15:0] in_led;
    logic [4:0]  out_led;
    logic        out_overflow;
    logic [2:0]  out_fifo_count;

    int total = 0;
    int bad   = 0;
    logic [15:0] exp_q[$];

    led_sequencer #(.HOLD_LOG2(2)) dut (
        .in_clock       (in_clock),
        .in_reset       (in_reset),
        .in_led         (in_led),
        .out_led        (out_led),
        .out_overflow   (out_overflow),
        .out_fifo_count (out_fifo_count)
    );

    initial in_clock = 1'b0;
    always #5 in_clock = ~in_clock;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge in_clock);
        #1;
    endtask

    // Expected LED value k clocks into a word: four 4-clock nibbles, then a 4-clock gap.
    function automatic logic [4:0] exp_at(input logic [15:0] w, input int k);
        int idx;
        if (k >= 16) return 5'h00;
        idx = 3 - k / 4;
        return {(k < 4), w[idx*4 +: 4]};
    endfunction

    // Monitor: a rising marker starts a word; the next 20 samples must match the queued word.
    logic        mon_active = 1'b0;
    logic        prev_mark  = 1'b0;
    int          mon_k      = 0;
    logic [15:0] mon_word   = 16'h0000;

    always @(negedge in_clock) begin
        if (in_reset) begin
            mon_active = 1'b0;
            prev_mark  = 1'b0;
        end else begin
            if (!mon_active && out_led[4] && !prev_mark) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", {11'd0, out_led}, 16'h0000);
                end else begin
                    mon_word   = exp_q.pop_front();
                    mon_active = 1'b1;
                    mon_k      = 0;
                    $display("word %h displaying at %0t", mon_word, $time);
                end
            end
            if (mon_active) begin
                check("word_led", {11'd0, out_led}, {11'd0, exp_at(mon_word, mon_k)});
                mon_k++;
                if (mon_k == 20) mon_active = 1'b0;
            end else if (!(out_led[4] && !prev_mark)) begin
                check("idle_led", {11'd0, out_led}, 16'h0000);
            end
            prev_mark = out_led[4];
        end
    end

    initial begin
        logic [2:0] c1, c2, c3;
        in_reset = 1'b1;
        in_led   = 16'h0000;
        #1;
        check("rst_led", {11'd0, out_led}, 16'h0000);
        check("rst_ovf", {15'd0, out_overflow}, 16'h0000);
        check("rst_cnt", {13'd0, out_fifo_count}, 16'h0000);
        step(2);
        in_reset = 1'b0;
        step(3);
        check("zero_no_push", {13'd0, out_fifo_count}, 16'h0000);

        // Single value with latency checks
        in_led = 16'hA5C3;
        exp_q.push_back(16'hA5C3);
        step(1);
        check("lat_cnt_e0", {13'd0, out_fifo_count}, 16'h0001);
        check("lat_led_e0", {11'd0, out_led}, 16'h0000);
        step(1);
        check("lat_cnt_e1", {13'd0, out_fifo_count}, 16'h0000);
        check("lat_led_e1", {11'd0, out_led}, 16'h001A);
        step(30);

        // Back-to-back changes
        in_led = 16'h1111; exp_q.push_back(16'h1111); step(1); c1 = out_fifo_count;
        in_led = 16'h2222; exp_q.push_back(16'h2222); step(1); c2 = out_fifo_count;
        in_led = 16'h3333; exp_q.push_back(16'h3333); step(1); c3 = out_fifo_count;
        check("b2b_cnt0", {13'd0, c1}, 16'h0001);
        check("b2b_cnt1", {13'd0, c2}, 16'h0001);
        check("b2b_cnt2", {13'd0, c3}, 16'h0002);
        step(70);

        // Overflow: six values, sixth dropped
        in_led = 16'h1234; exp_q.push_back(16'h1234); step(1);
        in_led = 16'h5678; exp_q.push_back(16'h5678); step(1);
        in_led = 16'h9ABC; exp_q.push_back(16'h9ABC); step(1);
        in_led = 16'hDEF0; exp_q.push_back(16'hDEF0); step(1);
        in_led = 16'h0F1E; exp_q.push_back(16'h0F1E); step(1);
        check("ovf_full_cnt", {13'd0, out_fifo_count}, 16'h0004);
        check("ovf_pre", {15'd0, out_overflow}, 16'h0000);
        in_led = 16'h2D3C; step(1);
        check("ovf_drop_cnt", {13'd0, out_fifo_count}, 16'h0004);
        check("ovf_set", {15'd0, out_overflow}, 16'h0001);
        step(110);
        check("ovf_sticky", {15'd0, out_overflow}, 16'h0001);
        check("ovf_drained", {13'd0, out_fifo_count}, 16'h0000);

        // Full FIFO with push on the IDLE-pop edge
        in_reset = 1'b1;
        in_led   = 16'h0000;
        step(2);
        in_reset = 1'b0;
        check("rst2_ovf", {15'd0, out_overflow}, 16'h0000);
        step(2);
        in_led = 16'h0101; exp_q.push_back(16'h0101); step(1);
        in_led = 16'h0202; exp_q.push_back(16'h0202); step(1);
        in_led = 16'h0303; exp_q.push_back(16'h0303); step(1);
        in_led = 16'h0404; exp_q.push_back(16'h0404); step(1);
        in_led = 16'h0505; exp_q.push_back(16'h0505); step(1);
        step(17);
        check("pp_pre_cnt", {13'd0, out_fifo_count}, 16'h0004);
        check("pp_pre_led", {11'd0, out_led}, 16'h0000);
        in_led = 16'h0606; exp_q.push_back(16'h0606); step(1);
        check("pp_cnt", {13'd0, out_fifo_count}, 16'h0004);
        check("pp_ovf", {15'd0, out_overflow}, 16'h0000);
        check("pp_led", {11'd0, out_led}, 16'h0010);
        step(130);

        // Reset during nibble 2 with three entries queued
        in_led = 16'hCAFE; exp_q.push_back(16'hCAFE); step(1);
        in_led = 16'hBEEF; exp_q.push_back(16'hBEEF); step(1);
        in_led = 16'h1357; exp_q.push_back(16'h1357); step(1);
        in_led = 16'h2468; exp_q.push_back(16'h2468); step(1);
        check("mid_cnt", {13'd0, out_fifo_count}, 16'h0003);
        step(3);
        check("mid_nib2", {11'd0, out_led}, 16'h000A);
        #1;
        in_reset = 1'b1;
        in_led   = 16'h0000;
        #1;
        check("async_led", {11'd0, out_led}, 16'h0000);
        check("async_cnt", {13'd0, out_fifo_count}, 16'h0000);
        exp_q.delete();
        step(2);
        in_reset = 1'b0;
        step(30);
        check("post_rst_led", {11'd0, out_led}, 16'h0000);
        check("post_rst_cnt", {13'd0, out_fifo_count}, 16'h0000);

        // 0 -> 1 -> 0: both transitions displayed
        in_led = 16'h0001; exp_q.push_back(16'h0001); step(1);
        in_led = 16'h0000; exp_q.push_back(16'h0000); step(1);
        check("pulse_cnt", {13'd0, out_fifo_count}, 16'h0001);
        step(50);

        check("queue_drained", exp_q.size(), 16'h0000);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
